imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pd5 pipeline.
- Picks one owner per transaction, drives the memory request, waits for the response and routes it back to the owner.
- Data has priority, with a starvation bound for fetch, and outstanding fetches can be cancelled on a PC redirect.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width (multiple of 8).
- STARVE_MAX, 4, consecutive conflicts data may win before fetch is forced to win; 0 means fetch always wins conflicts.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_req_i  input  1  fetch read request, held until if_gnt_o.
- if_addr_i  input  AWIDTH  fetch address.
- if_flush_i  input  1  PC redirect; cancel fetch transaction.
- if_gnt_o  output  1  fetch request accepted (1-cycle pulse).
- if_rvalid_o  output  1  fetch response valid (1-cycle pulse).
- if_rdata_o  output  DWIDTH  fetch read data.
- d_req_i  input  1  data request, held until d_gnt_o.
- d_we_i  input  1  1 = store, 0 = load.
- d_addr_i  input  AWIDTH  data address.
- d_wdata_i  input  DWIDTH  store data.
- d_be_i  input  DWIDTH/8  store byte enables.
- d_gnt_o  output  1  data request accepted.
- d_rvalid_o  output  1  data response (load data or store ack).
- d_rdata_o  output  DWIDTH  load data.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write.
- mem_addr_o  output  AWIDTH  memory address.
- mem_wdata_o  output  DWIDTH  memory write data.
- mem_be_o  output  DWIDTH/8  memory byte enables (all ones for reads).
- mem_ready_i  input  1  memory accepts request this cycle.
- mem_rvalid_i  input  1  memory response (reads and writes).
- mem_rdata_i  input  DWIDTH  memory read data.
- busy_o  output  1  state != IDLE.
- err_o  output  1  sticky: mem_rvalid_i seen outside WAIT.

Behaviour:
- Reset (asynchronous): state=IDLE; owner=fetch; starve_cnt=0; drop=0; err_o=0. All outputs 0.
- FSM states: IDLE, REQ, WAIT.
- Arbitration runs in IDLE, and in WAIT on the mem_rvalid_i cycle.
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt==STARVE_MAX, then fetch wins.
  - Data wins a conflict: starve_cnt++. Fetch wins: starve_cnt=0.
  - Winner's address, we, wdata and be are latched into registers. Next state is REQ.
- REQ:
  - mem_req_o=1; mem_* driven from the latched registers only.
  - mem_ready_i=1: owner's gnt pulses this cycle, then state goes to WAIT.
  - mem_ready_i=0: hold; the owner never changes in REQ.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i: owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle (combinational route), unless drop=1.
  - Then re-arbitrate: a pending request goes directly to REQ; otherwise IDLE.
- Latency: request in IDLE at cycle N gives mem_req_o at N+1. Earliest gnt is N+1; earliest response is N+2.
- rdata_o for non-owners: 0. d_rdata_o on a store ack: don't-care.
- Flush (if_flush_i=1):
  - Fetch winning in IDLE/WAIT arbitration this cycle: fetch is treated as not requesting.
  - REQ, owner fetch, mem_ready_i=0: go to IDLE, no grant.
  - REQ, owner fetch, mem_ready_i=1: the transaction issues and if_gnt_o=0. Set drop=1.
  - WAIT, owner fetch: set drop=1; the response is consumed with if_rvalid_o=0. drop clears on that response.
  - Owner data: flush has no effect on the data transaction.
- mem_rvalid_i in IDLE or REQ: ignored, err_o=1 until reset.
- Single outstanding transaction only.
- Assertion in the bench: the requester keeps req/addr stable until gnt.

Test Plan:
- Fetch only, addr 0x01000000, mem_ready=1, response 1 cycle later with rdata 0x00000013. Required: mem_req_o at N+1, if_gnt_o at N+1, if_rvalid_o at N+2 with 0x00000013.
- Both requesting continuously, STARVE_MAX=4. Required grant order D,D,D,D,F,D,D,D,D,F.
- Fetch in WAIT, if_flush_i pulses, memory returns 0xDEADBEEF. Required: if_rvalid_o stays 0, busy_o drops, and a following data request is served normally.
- Data store, we=1, be=4'b0011, addr 0x01000100, mem_ready low for 3 cycles. Required: mem_* stable for 4 cycles, d_gnt_o on the ready cycle, d_rvalid_o on the ack.
- mem_rvalid_i pulsed in IDLE → err_o=1 and stays 1. Then rst asserted mid-WAIT → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/data arbiter for the shared unified memory port
// One transaction in flight; data wins conflicts until fetch has lost STARVE_MAX in a row.
module imem_dmem_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int BW = DWIDTH / 8;
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              drop;
  logic [CW-1:0]     starve_cnt;
  logic [AWIDTH-1:0] addr_q;
  logic              we_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [BW-1:0]     be_q;

  logic rsp_cycle;
  logic arb_en;
  logic f_req;
  logic conflict;
  logic pick_d;
  logic pick_f;
  logic f_cancel;

  assign rsp_cycle = (state == WAIT) && mem_rvalid_i;
  assign arb_en    = (state == IDLE) || rsp_cycle;
  // A redirected fetch is invisible to arbitration in the same cycle.
  assign f_req     = if_req_i && !if_flush_i;
  assign conflict  = f_req && d_req_i;
  assign pick_d    = arb_en && d_req_i && !(f_req && (starve_cnt == STARVE_LIM));
  assign pick_f    = arb_en && f_req && !pick_d;
  assign f_cancel  = (owner == OWN_F) && if_flush_i;

  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  assign if_gnt_o    = (state == REQ) && (owner == OWN_F) && mem_ready_i && !if_flush_i;
  assign d_gnt_o     = (state == REQ) && (owner == OWN_D) && mem_ready_i;
  assign if_rvalid_o = rsp_cycle && (owner == OWN_F) && !drop && !if_flush_i;
  assign d_rvalid_o  = rsp_cycle && (owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_F;
      drop       <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d || pick_f) state <= REQ;
        end
        REQ: begin
          if (mem_ready_i) begin
            state <= WAIT;
            if (f_cancel) drop <= 1'b1;
          end else if (f_cancel) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (f_cancel) drop <= 1'b1;
          if (mem_rvalid_i) begin
            drop  <= 1'b0;
            state <= (pick_d || pick_f) ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pick_d) begin
        owner   <= OWN_D;
        addr_q  <= d_addr_i;
        we_q    <= d_we_i;
        wdata_q <= d_wdata_i;
        be_q    <= d_we_i ? d_be_i : '1;
        if (conflict) starve_cnt <= starve_cnt + CW'(1);
      end else if (pick_f) begin
        owner      <= OWN_F;
        addr_q     <= if_addr_i;
        we_q       <= 1'b0;
        wdata_q    <= '0;
        be_q       <= '1;
        starve_cnt <= '0;
      end

      if (mem_rvalid_i && (state != WAIT)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - scoreboard bench for imem_dmem_arbiter
// Expected responses are queued at grant time from a reference memory and popped on rvalid.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  imem_dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event occurred, expected none", nm);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0000_0013;
    if (a == 32'h0100_0040) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Reference memory (scoreboard side) and the memory device's own storage.
  logic [31:0] ref_mem   [logic [29:0]];
  logic [31:0] mem_store [logic [29:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a[31:2]) ? mem_store[a[31:2]] : init_word(a);
  endfunction

  function automatic logic outs_or();
    return |{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_gnt_o, if_rvalid_o,
             if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, busy_o, err_o};
  endfunction

  // Memory device knobs
  logic rnd_mode = 1'b0;
  int   rdy_dly  = 0;
  int   rsp_dly  = 0;
  int   inj_cnt  = 0;
  int   inj_done = 0;
  int   flush_cnt = 0;

  initial begin : mem_side
    int rd;
    int rs;
    logic [31:0] rdat;
    mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      if (inj_cnt != inj_done) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        inj_done++;
      end else if (!rst && mem_req_o) begin
        rd = rnd_mode ? int'($urandom_range(0, 2)) : rdy_dly;
        rs = rnd_mode ? int'($urandom_range(0, 2)) : rsp_dly;
        repeat (rd) begin @(posedge clk); #1; end
        mem_ready_i = 1'b1;
        if (mem_we_o) mem_store[mem_addr_o[31:2]] = merge(mem_rd(mem_addr_o), mem_wdata_o, mem_be_o);
        rdat = mem_rd(mem_addr_o);
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
        repeat (rs) begin @(posedge clk); #1; end
        if (!rst) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rdat;
          @(posedge clk); #1;
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = '0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Scoreboard: push at grant, pop at rvalid.
  logic [31:0] exp_f [$];
  logic [32:0] exp_d [$];
  logic        gnt_log [$];
  int          cancel_seen = 0;
  int          f_rv_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_f.delete();
      exp_d.delete();
    end else begin
      if (flush_cnt != cancel_seen) begin
        if (exp_f.size() > 0) void'(exp_f.pop_front());
        cancel_seen++;
      end
      if (if_gnt_o) begin
        exp_f.push_back(ref_rd(if_addr_i));
        gnt_log.push_back(1'b0);
      end
      if (d_gnt_o) begin
        if (d_we_i) begin
          ref_mem[d_addr_i[31:2]] = merge(ref_rd(d_addr_i), d_wdata_i, d_be_i);
          exp_d.push_back({1'b1, 32'h0});
        end else begin
          exp_d.push_back({1'b0, ref_rd(d_addr_i)});
        end
        gnt_log.push_back(1'b1);
      end
      if (mem_req_o && !mem_we_o) check("mem_be_read", {60'h0, mem_be_o}, 64'hF);
      if (if_rvalid_o) begin
        f_rv_cnt++;
        if (exp_f.size() == 0) fail_now("if_rvalid_unexpected");
        else check("if_rdata", {32'h0, if_rdata_o}, {32'h0, exp_f.pop_front()});
        check("d_rdata_nonowner", {32'h0, d_rdata_o}, 64'h0);
      end
      if (d_rvalid_o) begin
        if (exp_d.size() == 0) fail_now("d_rvalid_unexpected");
        else begin
          logic [32:0] e;
          e = exp_d.pop_front();
          if (!e[32]) check("d_rdata", {32'h0, d_rdata_o}, {32'h0, e[31:0]});
        end
        check("if_rdata_nonowner", {32'h0, if_rdata_o}, 64'h0);
      end
    end
  end

  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req_i && !if_gnt_o && !if_flush_i) |=> (if_req_i && $stable(if_addr_i)));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req_i && !d_gnt_o) |=> (d_req_i && $stable({d_we_i, d_addr_i, d_wdata_i, d_be_i})));

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    if_req_i  = 1'b1;
    if_addr_i = a;
    do begin @(negedge clk); n++; end while (!if_gnt_o && n < 200);
    if (!if_gnt_o) fail_now("if_gnt_timeout");
    @(posedge clk); #1;
    if_req_i = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    d_req_i = 1'b1; d_we_i = we; d_addr_i = a; d_wdata_i = wd; d_be_i = be;
    do begin @(negedge clk); n++; end while (!d_gnt_o && n < 200);
    if (!d_gnt_o) fail_now("d_gnt_timeout");
    @(posedge clk); #1;
    d_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
      while ((busy_o || exp_f.size() != 0 || exp_d.size() != 0) && n < 100);
    check("wait_idle_busy", {63'h0, busy_o}, 64'h0);
    check("wait_idle_pending", exp_f.size() + exp_d.size(), 64'h0);
    step(1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c0, t_mr, t_g, t_rv, base, rv0, n;
    logic [31:0] rv_data;
    logic [9:0]  order;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
    step(3);
    check("reset_outputs", {63'h0, outs_or()}, 64'h0);
    rst = 1'b0;
    step(2);
    check("idle_busy", {63'h0, busy_o}, 64'h0);

    // Fetch-only latency
    c0 = cyc; t_mr = -1; t_g = -1; t_rv = -1; rv_data = '0;
    fork
      do_fetch(32'h0100_0000);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (mem_req_o && t_mr < 0) t_mr = cyc;
        if (if_gnt_o) t_g = cyc;
        if (if_rvalid_o) begin t_rv = cyc; rv_data = if_rdata_o; end
      end
    join
    step(1);
    check("lat_mem_req", t_mr - c0, 64'd1);
    check("lat_if_gnt", t_g - c0, 64'd1);
    check("lat_if_rvalid", t_rv - c0, 64'd2);
    check("fetch_rdata", {32'h0, rv_data}, 64'h13);
    wait_idle();

    // Starvation bound: both requesting continuously
    base = gnt_log.size();
    fork
      for (int i = 0; i < 2; i++) do_fetch(32'h0100_0000 + 32'(i * 4));
      for (int i = 0; i < 8; i++) do_data(1'b0, 32'h0100_0010 + 32'(i * 4), 32'h0, 4'hF);
    join
    wait_idle();
    check("starve_grant_count", gnt_log.size() - base, 64'd10);
    order = '0;
    n = gnt_log.size() - base;
    for (int i = 0; i < 10 && i < n; i++) order[9 - i] = gnt_log[base + i];
    check("starve_order", {54'h0, order}, {54'h0, 10'b1111011110});

    // Flush while fetch is in WAIT
    rsp_dly = 3;
    do_fetch(32'h0100_0040);
    check("flush_pending", exp_f.size(), 64'd1);
    rv0 = f_rv_cnt;
    if_flush_i = 1'b1;
    flush_cnt++;
    step(1);
    if_flush_i = 1'b0;
    rsp_dly = 0;
    wait_idle();
    check("flush_no_rvalid", f_rv_cnt - rv0, 64'd0);
    do_data(1'b0, 32'h0100_0040, 32'h0, 4'hF);
    wait_idle();

    // Store with memory stalling 3 cycles
    rdy_dly = 3;
    fork
      do_data(1'b1, 32'h0100_0100, 32'hCAFE_F00D, 4'b0011);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_o && n < 20);
        for (int i = 0; i < 4; i++) begin
          check("store_mem_fields", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                {1'b1, 1'b1, 32'h0100_0100, 32'hCAFE_F00D, 4'b0011});
          check("store_d_gnt", {63'h0, d_gnt_o}, {63'h0, (i == 3)});
          @(negedge clk);
        end
      end
    join
    rdy_dly = 0;
    wait_idle();
    do_data(1'b0, 32'h0100_0100, 32'h0, 4'hF);
    wait_idle();

    // Stray response in IDLE, then async reset mid-WAIT
    check("err_before", {63'h0, err_o}, 64'h0);
    inj_cnt++;
    step(3);
    check("err_set", {63'h0, err_o}, 64'h1);
    step(5);
    check("err_sticky", {63'h0, err_o}, 64'h1);
    rsp_dly = 4;
    do_fetch(32'h0100_0000);
    check("in_wait", {busy_o, mem_req_o}, 64'h2);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {63'h0, outs_or()}, 64'h0);
    step(6);
    rst = 1'b0;
    rsp_dly = 0;
    step(2);
    check("post_reset_idle", {err_o, busy_o}, 64'h0);

    // Randomized traffic
    rnd_mode = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        step(int'($urandom_range(0, 3)));
        do_fetch(32'h0100_0000 | 32'($urandom_range(0, 15) << 2));
      end
      for (int i = 0; i < 25; i++) begin
        step(int'($urandom_range(0, 3)));
        do_data(1'($urandom_range(0, 1)), 32'h0100_0000 | 32'($urandom_range(0, 15) << 2),
                $urandom, 4'($urandom_range(1, 15)));
      end
    join
    rnd_mode = 1'b0;
    wait_idle();
    check("final_err", {63'h0, err_o}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
